// File: rtl/iobus_arbiter_pkg.sv
// Iobus_arb_pkg: shared types and constants for the I/O bus arbiter.
// Holds the master index type, default outstanding depth, error data.
package Iobus_arb_pkg;

  localparam int MAX_OUTST_DEF = 4;
  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  // wide enough for up to 8 masters
  typedef logic [2:0] mst_idx_t;

  // index + 1, wrapping at n
  function automatic mst_idx_t idx_inc(mst_idx_t i, int n);
    logic [3:0] s;
    s = {1'b0, i} + 4'd1;
    if (s >= 4'(n)) s = '0;
    return s[2:0];
  endfunction

endpackage

// File: rtl/iobus_arbiter_tag_fifo.sv
// iobus_tag_fifo: in-order FIFO of issuing master indices.
// Ports: clk, reset (async low), push/push_tag, pop, full, empty, head, count.
module iobus_tag_fifo
  import Iobus_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  mst_idx_t               push_tag,
  input  logic                   pop,
  output logic                   full,
  output logic                   empty,
  output mst_idx_t               head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  mst_idx_t      mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];

  // depth is a power of two, so pointers wrap on their own
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_tag;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/iobus_arbiter.sv
// iobus_arbiter: round-robin N-master arbiter onto one in-order I/O bus.
// Ports: m_* master side, s_* slave side, idle. Option: IOBUS_ARB_TIMEOUT_EN.
module iobus_arbiter
  import Iobus_arb_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int MAX_OUTST   = MAX_OUTST_DEF,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_MASTERS-1:0]       m_req,
  input  logic [N_MASTERS-1:0]       m_we,
  input  logic [N_MASTERS-1:0][31:0] m_addr,
  input  logic [N_MASTERS-1:0][31:0] m_wdata,
  output logic [N_MASTERS-1:0]       m_ack,
  output logic [N_MASTERS-1:0]       m_rvalid,
  output logic [31:0]                m_rdata,
  output logic                       m_err,
  output logic                       s_req,
  output logic                       s_we,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic                       s_ack,
  input  logic                       s_rvalid,
  input  logic [31:0]                s_rdata,
  output logic                       idle
);

  localparam int CW = $clog2(MAX_OUTST) + 1;

  logic                 s_req_q, s_req_d;
  logic                 s_we_q, s_we_d;
  logic [31:0]          s_addr_q, s_addr_d;
  logic [31:0]          s_wdata_q, s_wdata_d;
  mst_idx_t             gnt_q, gnt_d;
  mst_idx_t             rr_q, rr_d;

  logic                 accept;
  logic                 pop_rsp;
  logic                 tmo_fire;
  logic                 pop;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;
  mst_idx_t             head;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic [N_MASTERS-1:0] gnt_oh;
  logic [N_MASTERS-1:0] head_oh;

  logic [N_MASTERS-1:0] avail;
  logic [N_MASTERS-1:0] rot;
  mst_idx_t             off;
  logic [3:0]           sum;
  mst_idx_t             pick;
  logic                 pick_we;
  logic [31:0]          pick_addr;
  logic [31:0]          pick_wdata;

  assign accept  = s_req_q & s_ack;
  assign pop_rsp = s_rvalid & ~fifo_empty;
  assign pop     = pop_rsp | tmo_fire;
  assign push    = accept & ~fifo_full;
  assign cnt_nxt = cnt + CW'(accept) - CW'(pop);

  iobus_tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag (gnt_q),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head),
    .count    (cnt)
  );

`ifdef IOBUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_q;

  // counter value k-1 during the k-th waiting cycle
  assign tmo_fire = ~fifo_empty & ~s_rvalid
                  & (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else if (fifo_empty || s_rvalid || tmo_fire) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TW'(1);
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    gnt_oh  = '0;
    head_oh = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      gnt_oh[i]  = (gnt_q == mst_idx_t'(i));
      head_oh[i] = (head == mst_idx_t'(i));
    end
  end

  assign m_ack    = accept ? gnt_oh : '0;
  assign m_rvalid = pop ? head_oh : '0;
  assign m_rdata  = pop_rsp ? s_rdata : ERR_RDATA;
  assign m_err    = tmo_fire;

  assign s_req   = s_req_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign idle    = (cnt == '0) & ~s_req_q;

  // Arbitration runs on the edge that frees the bus; the master
  // being accepted is masked since its m_req is still high.
  always_comb begin
    avail = m_req & ~m_ack;
    rr_d  = accept ? idx_inc(gnt_q, N_MASTERS) : rr_q;
    rot   = N_MASTERS'({avail, avail} >> rr_d);
    off   = '0;
    for (int k = N_MASTERS - 1; k >= 0; k--) begin
      if (rot[k]) off = mst_idx_t'(k);
    end
    sum = {1'b0, rr_d} + {1'b0, off};
    if (sum >= 4'(N_MASTERS)) sum = sum - 4'(N_MASTERS);
    pick = sum[2:0];

    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (pick == mst_idx_t'(i)) begin
        pick_we    = m_we[i];
        pick_addr  = m_addr[i];
        pick_wdata = m_wdata[i];
      end
    end

    s_req_d   = s_req_q;
    gnt_d     = gnt_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    if (!s_req_q || s_ack) begin
      s_req_d = 1'b0;
      if ((|avail) && (cnt_nxt < CW'(MAX_OUTST))) begin
        s_req_d   = 1'b1;
        gnt_d     = pick;
        s_we_d    = pick_we;
        s_addr_d  = pick_addr;
        s_wdata_d = pick_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      gnt_q     <= '0;
      rr_q      <= '0;
    end else begin
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      gnt_q     <= gnt_d;
      rr_q      <= rr_d;
    end
  end

endmodule

// File: tb/tb_iobus_arbiter.sv
// tb_iobus_arbiter: directed and randomized checks of iobus_arbiter.
// Reference: queue of issuers plus a round-robin pointer.
module tb_iobus_arbiter;

  localparam int N   = 2;
  localparam int MAX = 4;
  localparam int TMO = 256;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       m_req, m_we, m_ack, m_rvalid;
  logic [N-1:0][31:0] m_addr, m_wdata;
  logic [31:0]        m_rdata, s_addr, s_wdata, s_rdata;
  logic               m_err, s_req, s_we, s_ack, s_rvalid, idle;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  iobus_arbiter #(
    .N_MASTERS   (N),
    .MAX_OUTST   (MAX),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_ack    (m_ack),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_ack    (s_ack),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata),
    .idle     (idle)
  );

  function automatic int rr_first(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; m_req = '0; m_we = '0;
    s_ack = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hdead_beef;
    #2;
    n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rst_s_req got %b want 0", s_req); end
    n_chk++; if (m_ack !== '0) begin n_fail++; $display("FAIL rst_m_ack got %b want 0", m_ack); end
    n_chk++; if (m_rvalid !== '0) begin n_fail++; $display("FAIL rst_m_rvalid got %b want 0", m_rvalid); end
    n_chk++; if (m_err !== 1'b0) begin n_fail++; $display("FAIL rst_m_err got %b want 0", m_err); end
    n_chk++; if (m_rdata !== '0) begin n_fail++; $display("FAIL rst_m_rdata got %h want 0", m_rdata); end
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b want 1", idle); end
    @(posedge clk);
    #1;
    reset = 1'b1; s_rvalid = 1'b0;
    tick();
    #2;
    n_chk++; if (idle !== 1'b1 || s_req !== 1'b0) begin
      n_fail++; $display("FAIL post_rst got idle=%b s_req=%b want 1/0", idle, s_req);
    end
  endtask

  task automatic test_alternate();
    int exp_q[$];
    int exp_g, n_acc, g;
    logic rsp_nxt;
    do_reset();
    m_addr[0] = 32'h0000_a000; m_addr[1] = 32'h0000_b000;
    m_wdata[0] = 32'h1111_0000; m_wdata[1] = 32'h2222_0000;
    m_we = 2'b01; m_req = 2'b11; s_ack = 1'b1;
    exp_g = 0; n_acc = 0; rsp_nxt = 1'b0;
    for (int c = 0; c < 20; c++) begin
      s_rvalid = rsp_nxt; s_rdata = $urandom;
      #2;
      if (s_rvalid) begin
        g = exp_q.pop_front();
        n_chk++; if (m_rvalid !== N'(1 << g) || m_rdata !== s_rdata) begin
          n_fail++; $display("FAIL alt_rvalid got %b/%h want %b/%h", m_rvalid, m_rdata, N'(1 << g), s_rdata);
        end
      end
      rsp_nxt = 1'b0;
      if (m_ack !== '0) begin
        n_chk++; if (m_ack !== N'(1 << exp_g) || s_addr !== m_addr[exp_g]) begin
          n_fail++; $display("FAIL alt_grant got %b/%h want %b/%h", m_ack, s_addr, N'(1 << exp_g), m_addr[exp_g]);
        end
        exp_q.push_back(exp_g);
        exp_g = (exp_g + 1) % N;
        n_acc++;
        rsp_nxt = 1'b1;
      end
      tick();
    end
    n_chk++; if (n_acc != 19) begin n_fail++; $display("FAIL alt_count got %0d want 19", n_acc); end
    m_req = '0; s_rvalid = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    m_addr[0] = 32'h0000_0c00; m_addr[1] = 32'h0000_0d00;
    m_req = 2'b10; s_ack = 1'b0;
    #2;
    n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL hold_pre got %b want 0", s_req); end
    tick();
    m_req = 2'b11;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_chk++; if (s_req !== 1'b1 || s_addr !== m_addr[1] || m_ack !== '0) begin
        n_fail++; $display("FAIL hold_stall got %b/%h/%b want 1/%h/00", s_req, s_addr, m_ack, m_addr[1]);
      end
      tick();
    end
    s_ack = 1'b1;
    #2;
    n_chk++; if (m_ack !== 2'b10 || s_addr !== m_addr[1]) begin
      n_fail++; $display("FAIL hold_acc1 got %b/%h want 10/%h", m_ack, s_addr, m_addr[1]);
    end
    tick();
    m_req = 2'b01;
    #2;
    n_chk++; if (m_ack !== 2'b01 || s_addr !== m_addr[0]) begin
      n_fail++; $display("FAIL hold_acc0 got %b/%h want 01/%h", m_ack, s_addr, m_addr[0]);
    end
    tick();
    m_req = '0; s_ack = 1'b0;
  endtask

  task automatic test_full();
    int n;
    do_reset();
    m_req = 2'b11; s_ack = 1'b1; n = 0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (m_ack !== '0) n++;
      tick();
    end
    n_chk++; if (n != MAX) begin n_fail++; $display("FAIL full_count got %0d want %0d", n, MAX); end
    #2;
    n_chk++; if (s_req !== 1'b0 || idle !== 1'b0) begin
      n_fail++; $display("FAIL full_sreq got %b/%b want 0/0", s_req, idle);
    end
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    #2;
    n_chk++; if (m_rvalid !== 2'b01 || m_rdata !== 32'h1234_5678 || m_ack !== '0) begin
      n_fail++; $display("FAIL full_pop got %b/%h/%b want 01/12345678/00", m_rvalid, m_rdata, m_ack);
    end
    tick();
    s_rvalid = 1'b0; n = 0;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (m_ack !== '0) n++;
      tick();
    end
    n_chk++; if (n != 1) begin n_fail++; $display("FAIL full_resume got %0d want 1", n); end
    #2;
    n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL full_again got %b want 0", s_req); end
    m_req = '0; s_ack = 1'b0;
  endtask

  task automatic test_simul();
    int n;
    do_reset();
    m_req = 2'b11; s_ack = 1'b1; n = 0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      #2;
      if (m_ack !== '0) n++;
      tick();
    end
    n_chk++; if (n != 2) begin n_fail++; $display("FAIL simul_pre got %0d want 2", n); end
    s_rvalid = 1'b1; s_rdata = 32'h5a5a_0001;
    #2;
    n_chk++; if (m_ack !== 2'b01 || m_rvalid !== 2'b01 || m_rdata !== 32'h5a5a_0001) begin
      n_fail++; $display("FAIL simul_edge got %b/%b/%h want 01/01/5a5a0001", m_ack, m_rvalid, m_rdata);
    end
    tick();
    s_rvalid = 1'b0; n = 0;
    for (int c = 0; c < 10; c++) begin
      #2;
      if (m_ack !== '0) n++;
      tick();
    end
    n_chk++; if (n != 2) begin n_fail++; $display("FAIL simul_count got %0d want 2", n); end
    s_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      s_rvalid = 1'b1; s_rdata = $urandom;
      #2;
      n_chk++; if (m_rvalid !== N'(1 << ((c + 1) % 2)) || m_rdata !== s_rdata) begin
        n_fail++; $display("FAIL simul_order%0d got %b want %b", c, m_rvalid, N'(1 << ((c + 1) % 2)));
      end
      tick();
    end
    s_rvalid = 1'b1; s_rdata = 32'hffff_0000;
    #2;
    n_chk++; if (m_rvalid !== '0 || m_rdata !== '0) begin
      n_fail++; $display("FAIL simul_drop got %b/%h want 00/0", m_rvalid, m_rdata);
    end
    tick();
    s_rvalid = 1'b0; m_req = '0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    m_req = 2'b11; s_ack = 1'b1; n = 0;
    for (int c = 0; c < 10 && n < 3; c++) begin
      #2;
      if (m_ack !== '0) n++;
      tick();
    end
    n_chk++; if (n != 3) begin n_fail++; $display("FAIL rmid_pre got %0d want 3", n); end
    s_ack = 1'b0; reset = 1'b0;
    #2;
    n_chk++; if (s_req !== 1'b0 || idle !== 1'b1 || m_ack !== '0) begin
      n_fail++; $display("FAIL rmid_rst got %b/%b/%b want 0/1/00", s_req, idle, m_ack);
    end
    tick();
    reset = 1'b1; m_req = '0; s_rvalid = 1'b1; s_rdata = 32'hbad0_0001;
    #2;
    n_chk++; if (m_rvalid !== '0 || idle !== 1'b1) begin
      n_fail++; $display("FAIL rmid_stray got %b/%b want 00/1", m_rvalid, idle);
    end
    tick();
    s_rvalid = 1'b0; m_req = 2'b11; s_ack = 1'b1;
    tick();
    #2;
    n_chk++; if (m_ack !== 2'b01) begin n_fail++; $display("FAIL rmid_rr got %b want 01", m_ack); end
    tick();
    m_req = '0; s_ack = 1'b0;
  endtask

`ifdef IOBUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k, n;
    do_reset();
    m_req = 2'b01; s_ack = 1'b1; n = 0;
    for (int c = 0; c < 5 && n == 0; c++) begin
      #2;
      if (m_ack !== '0) n++;
      tick();
    end
    n_chk++; if (n != 1) begin n_fail++; $display("FAIL tmo_accept got %0d want 1", n); end
    m_req = '0; s_ack = 1'b0; k = 0;
    for (int c = 1; c <= TMO + 20 && k == 0; c++) begin
      #2;
      if (m_rvalid !== '0) begin
        k = c;
        n_chk++; if (m_rvalid !== 2'b01 || m_err !== 1'b1 || m_rdata !== '0) begin
          n_fail++; $display("FAIL tmo_resp got %b/%b/%h want 01/1/0", m_rvalid, m_err, m_rdata);
        end
      end
      tick();
    end
    n_chk++; if (k != TMO) begin n_fail++; $display("FAIL tmo_cycle got %0d want %0d", k, TMO); end
    #2;
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL tmo_idle got %b want 1", idle); end
  endtask
`endif

  task automatic test_random();
    int q[$];
    int cur, rr, g;
    logic [N-1:0] avail, done, exp_rv, exp_ack;
    do_reset();
    cur = -1; rr = 0; avail = '0; done = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (done[i]) m_req[i] = 1'b0;
        if (!m_req[i] && !done[i] && $urandom_range(3) == 0) begin
          m_req[i] = 1'b1; m_we[i] = 1'($urandom);
          m_addr[i] = $urandom; m_wdata[i] = $urandom;
        end
      end
      done = '0;
      s_ack = ($urandom_range(2) != 0);
      s_rvalid = ($urandom_range(2) == 0);
      s_rdata = $urandom;
      #2;
      if (q.size() > 0) begin
        n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rnd_idle c%0d got %b want 0", c, idle); end
      end
      if (q.size() == MAX) begin
        n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rnd_full c%0d got %b want 0", c, s_req); end
      end
      if (s_req === 1'b1 && cur < 0) begin
        g = rr_first(avail, rr);
        n_chk++; if (g < 0) begin
          n_fail++; $display("FAIL rnd_spurious c%0d got s_req=1 want 0", c);
        end
        cur = g;
      end
      if (s_req === 1'b1 && cur >= 0) begin
        n_chk++; if (s_addr !== m_addr[cur] || s_wdata !== m_wdata[cur] || s_we !== m_we[cur]) begin
          n_fail++; $display("FAIL rnd_payload c%0d got %h want %h (m%0d)", c, s_addr, m_addr[cur], cur);
        end
      end
      exp_ack = (s_req === 1'b1 && s_ack && cur >= 0) ? N'(1 << cur) : '0;
      n_chk++; if (m_ack !== exp_ack) begin
        n_fail++; $display("FAIL rnd_ack c%0d got %b want %b", c, m_ack, exp_ack);
      end
      exp_rv = (s_rvalid && q.size() > 0) ? N'(1 << q[0]) : '0;
      n_chk++; if (m_rvalid !== exp_rv || m_err !== 1'b0 || (exp_rv != '0 && m_rdata !== s_rdata)) begin
        n_fail++; $display("FAIL rnd_rvalid c%0d got %b/%b/%h want %b/0/%h", c, m_rvalid, m_err, m_rdata, exp_rv, s_rdata);
      end
      if (exp_rv != '0) void'(q.pop_front());
      avail = m_req;
      if (exp_ack != '0) begin
        q.push_back(cur);
        rr = (cur + 1) % N;
        avail[cur] = 1'b0;
        done[cur] = 1'b1;
        cur = -1;
      end
      tick();
    end
    m_req = '0; s_ack = 1'b0; s_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_hold();
    test_full();
    test_simul();
    test_reset_mid();
`ifdef IOBUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/iobus_arbiter.md
IOBUS_ARBITER -- requirements
Module: iobus_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 2: number of requesters sharing the device-control I/O bus (2..8).
REQ-002 Parameter MAX_OUTST, default 4: maximum accepted-but-unanswered transactions (power of two, 2..16).
REQ-003 Parameter TIMEOUT_CYC, default 256: response timeout in cycles (used only with IOBUS_ARB_TIMEOUT_EN).
REQ-004 Port clk  in  1  single clock; all logic is rising-edge.
REQ-005 Port reset  in  1  asynchronous, active-low reset.
REQ-006 Port m_req  in  N_MASTERS  per-master request; held until m_ack.
REQ-007 Port m_we  in  N_MASTERS  per-master write enable.
REQ-008 Port m_addr  in  N_MASTERS x 32  per-master word address.
REQ-009 Port m_wdata  in  N_MASTERS x 32  per-master write data.
REQ-010 Port m_ack  out  N_MASTERS  one-hot request-accept pulse.
REQ-011 Port m_rvalid  out  N_MASTERS  one-hot response strobe.
REQ-012 Port m_rdata  out  32  response data, shared by all masters.
REQ-013 Port m_err  out  1  response is a timeout error; qualified by m_rvalid.
REQ-014 Port s_req, s_we, s_addr(32), s_wdata(32)  out  slave request to the I/O bus.
REQ-015 Port s_ack  in  1  slave accepts the request presented this cycle.
REQ-016 Port s_rvalid  in  1, s_rdata  in  32  slave response; one per accepted request, in order.
REQ-017 Port idle  out  1  no pending request and no outstanding transaction.

Function
REQ-018 A transaction is accepted when s_req and s_ack are both high on a rising edge; m_ack of the granted master is s_req & s_ack (combinational, same cycle).
REQ-019 Grant is round-robin: search starts at rr_ptr; rr_ptr becomes granted index+1 (mod N_MASTERS) on acceptance only.
REQ-020 Once s_req is raised for a master, grant and s_* payload are held stable until s_ack; no re-arbitration mid-request.
REQ-021 s_req is low while outstanding count equals MAX_OUTST (full); arbitration resumes the cycle after a response pops.
REQ-022 Each acceptance pushes the granted index into an in-order tag FIFO; each s_rvalid pops the head.
REQ-023 s_rvalid routes combinationally: m_rvalid[head]=1, m_rdata=s_rdata, m_err=0; zero-cycle latency.
REQ-024 Simultaneous accept and response: push and pop both happen, count unchanged; full-and-pop in the same cycle does not allow a same-cycle accept.
REQ-025 s_rvalid with empty FIFO is dropped; no m_rvalid asserted.
REQ-026 idle = (count==0) & ~s_req.

Reset
REQ-027 On reset low: s_req=0, m_ack=0, m_rvalid=0, m_err=0, m_rdata=0, rr_ptr=0, count=0, FIFO pointers=0, timeout counter=0, idle=1.
REQ-028 Reset assertion mid-transaction discards all outstanding tags; late s_rvalid after reset is dropped per REQ-025.

Configuration
REQ-029 Macro IOBUS_ARB_TIMEOUT_EN defined: counter increments each cycle with count>0 and no s_rvalid, clears on s_rvalid; at TIMEOUT_CYC it pops the head, pulses m_rvalid[head] with m_err=1, m_rdata=0, and clears.
REQ-030 Macro undefined: no counter is built; m_err tied 0; a missing response stalls indefinitely.

Structure
REQ-031 Master index typedef, MAX_OUTST default and error-data constant live in shared package Iobus_arb_pkg.
REQ-032 The tag FIFO is sub-module iobus_tag_fifo (depth MAX_OUTST, push/pop/full/empty/head).

Verification
REQ-033 Both masters request, s_ack=1, responses 1 cycle later -> grants alternate M0,M1,M0,M1; each m_rvalid routed to its issuer.
REQ-034 M1 requests, s_ack low for 3 cycles while M0 also requests -> s_addr/grant stay on M1 until s_ack; M0 accepted next.
REQ-035 MAX_OUTST=4, s_rvalid withheld -> 4 acceptances, then s_req=0; one s_rvalid -> exactly one further acceptance.
REQ-036 Accept and s_rvalid on the same edge at count=2 -> count stays 2; tag order preserved.
REQ-037 Timeout build, TIMEOUT_CYC=256, no response -> on cycle 256 m_rvalid to issuer, m_err=1, m_rdata=0, count decrements.
REQ-038 Reset low with 3 outstanding, then stray s_rvalid -> no m_rvalid; idle=1; rr_ptr=0.
